// File: rtl/odd_count_checker.sv
// Lock-on monitor for an odd-sequence counter: locks after LOCK_LEN good samples, then flags parity/step errors.
// Optional ODD_CHK_AUTO_RESYNC_EN: FAULT recovers on the next valid sample instead of waiting for clear.
module odd_count_checker #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STEP      = 2,
    parameter int unsigned LOCK_LEN  = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_count,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 err_parity,
    output logic                 err_step,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 wrap_pulse,
    output logic [WIDTH-1:0]     exp_count
);
    localparam int unsigned GOOD_W = $clog2(LOCK_LEN + 1);
    localparam logic [WIDTH-1:0]     STEP_V  = WIDTH'(STEP);
    localparam logic [GOOD_W-1:0]    LOCK_V  = GOOD_W'(LOCK_LEN);
    localparam logic [GOOD_W-1:0]    GOOD_1  = GOOD_W'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_1   = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [GOOD_W-1:0]      good_cnt, good_nxt;
    logic [WIDTH-1:0]       exp_nxt;
    logic [WIDTH-1:0]       prev_count;
    logic [ERR_CNT_W-1:0]   cnt_nxt;
    logic                   is_odd, is_match;
    logic                   err_evt, par_evt, step_evt;
    logic                   err_nxt, wrap_nxt, parity_nxt, stepf_nxt, locked_nxt;

    assign is_odd     = in_count[0];
    assign is_match   = (in_count == exp_count);
    // On a matching sample the previously accepted value is exactly one step back.
    assign prev_count = in_count - STEP_V;

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        exp_nxt   = exp_count;
        err_evt   = 1'b0;
        par_evt   = 1'b0;
        step_evt  = 1'b0;
        wrap_nxt  = 1'b0;

        if (in_valid) begin
            case (state)
                UNLOCKED: begin
                    if (is_odd) begin
                        exp_nxt   = in_count + STEP_V;
                        good_nxt  = GOOD_1;
                        state_nxt = LOCKING;
                    end else begin
                        err_evt = 1'b1;
                        par_evt = 1'b1;
                    end
                end
                LOCKING: begin
                    if (is_match) begin
                        good_nxt = good_cnt + GOOD_1;
                        exp_nxt  = in_count + STEP_V;
                        if ((good_cnt + GOOD_1) == LOCK_V) begin
                            state_nxt = LOCKED;
                        end
                    end else if (is_odd) begin
                        exp_nxt  = in_count + STEP_V;
                        good_nxt = GOOD_1;
                    end else begin
                        err_evt   = 1'b1;
                        par_evt   = 1'b1;
                        good_nxt  = '0;
                        state_nxt = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (is_match) begin
                        exp_nxt  = in_count + STEP_V;
                        wrap_nxt = (in_count < prev_count);
                    end else begin
                        err_evt   = 1'b1;
                        step_evt  = 1'b1;
                        par_evt   = ~is_odd;
                        state_nxt = FAULT;
                    end
                end
                FAULT: begin
`ifdef ODD_CHK_AUTO_RESYNC_EN
                    if (is_odd) begin
                        exp_nxt   = in_count + STEP_V;
                        good_nxt  = GOOD_1;
                        state_nxt = LOCKING;
                    end else begin
                        good_nxt  = '0;
                        state_nxt = UNLOCKED;
                    end
`endif
                end
                default: begin
                    good_nxt  = '0;
                    state_nxt = UNLOCKED;
                end
            endcase
        end

        // Clear drops a coincident error and leaves FAULT; otherwise the FSM runs as normal.
        if (clear && ((state == FAULT) || err_evt)) begin
            state_nxt = UNLOCKED;
            good_nxt  = '0;
            exp_nxt   = exp_count;
        end

        err_nxt    = err_evt & ~clear;
        parity_nxt = clear ? 1'b0 : (err_parity | par_evt);
        stepf_nxt  = clear ? 1'b0 : (err_step | step_evt);
        if (clear) begin
            cnt_nxt = '0;
        end else if (err_evt && (err_count != CNT_MAX)) begin
            cnt_nxt = err_count + CNT_1;
        end else begin
            cnt_nxt = err_count;
        end
        locked_nxt = (state_nxt == LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= UNLOCKED;
            good_cnt   <= '0;
            exp_count  <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_parity <= 1'b0;
            err_step   <= 1'b0;
            err_count  <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            good_cnt   <= good_nxt;
            exp_count  <= exp_nxt;
            locked     <= locked_nxt;
            err_pulse  <= err_nxt;
            err_parity <= parity_nxt;
            err_step   <= stepf_nxt;
            err_count  <= cnt_nxt;
            wrap_pulse <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_odd_count_checker.sv
// Bench for odd_count_checker: directed vector table, hand-written corner sequences, and random
// stimulus against a run-length reference model (ODD_CHK_AUTO_RESYNC_EN selects the FAULT recovery rule).
module tb_odd_count_checker;
    localparam int WIDTH     = 8;
    localparam int STEP      = 2;
    localparam int LOCK_LEN  = 4;
    localparam int ERR_CNT_W = 8;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_count;
    logic                 clear;
    logic                 locked;
    logic                 err_pulse;
    logic                 err_parity;
    logic                 err_step;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 wrap_pulse;
    logic [WIDTH-1:0]     exp_count;

    always #5 clk = ~clk;

    odd_count_checker #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .LOCK_LEN (LOCK_LEN),
        .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_count  (in_count),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_parity(err_parity),
        .err_step  (err_step),
        .err_count (err_count),
        .wrap_pulse(wrap_pulse),
        .exp_count (exp_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: run length of accepted samples, previous accepted value, fault flag.
    int m_run   = 0;
    int m_exp   = 0;
    int m_prev  = 0;
    bit m_fault = 1'b0;
    bit m_par   = 1'b0;
    bit m_stp   = 1'b0;
    bit m_ep    = 1'b0;
    bit m_wr    = 1'b0;
    int m_cnt   = 0;

    task automatic model_step(input bit rst, input bit v, input int c, input bit clr);
        bit err;
        bit par_e;
        bit stp_e;
        err   = 1'b0;
        par_e = 1'b0;
        stp_e = 1'b0;
        m_ep  = 1'b0;
        m_wr  = 1'b0;
        if (rst) begin
            m_run = 0; m_exp = 0; m_prev = 0; m_fault = 1'b0;
            m_par = 1'b0; m_stp = 1'b0; m_cnt = 0;
            return;
        end
        if (m_fault) begin
            if (clr) begin
                m_fault = 1'b0;
                m_run   = 0;
            end else if (v) begin
`ifdef ODD_CHK_AUTO_RESYNC_EN
                m_fault = 1'b0;
                if (c % 2 == 1) begin
                    m_run = 1; m_exp = (c + STEP) % 256; m_prev = c;
                end else begin
                    m_run = 0;
                end
`endif
            end
        end else if (v) begin
            if (m_run > 0 && c == m_exp) begin
                if (m_run >= LOCK_LEN && c < m_prev) m_wr = 1'b1;
                m_run++;
                m_exp  = (c + STEP) % 256;
                m_prev = c;
            end else if (m_run >= LOCK_LEN) begin
                err   = 1'b1;
                stp_e = 1'b1;
                par_e = (c % 2 == 0);
                if (clr) m_run = 0;
                else     m_fault = 1'b1;
            end else if (c % 2 == 1) begin
                m_run = 1; m_exp = (c + STEP) % 256; m_prev = c;
            end else begin
                err   = 1'b1;
                par_e = 1'b1;
                m_run = 0;
            end
        end
        if (clr) begin
            m_par = 1'b0; m_stp = 1'b0; m_cnt = 0;
        end else begin
            m_par = m_par | par_e;
            m_stp = m_stp | stp_e;
            if (err && m_cnt < 255) m_cnt++;
            m_ep = err;
        end
    endtask

    task automatic drive(input bit rst, input bit v, input logic [7:0] c, input bit clr);
        reset    = ~rst;
        in_valid = v;
        in_count = c;
        clear    = clr;
        @(posedge clk);
        #1;
        model_step(rst, v, int'(c), clr);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".locked"},     int'(locked),     int'(!m_fault && m_run >= LOCK_LEN));
        chk({tag, ".err_pulse"},  int'(err_pulse),  int'(m_ep));
        chk({tag, ".err_parity"}, int'(err_parity), int'(m_par));
        chk({tag, ".err_step"},   int'(err_step),   int'(m_stp));
        chk({tag, ".err_count"},  int'(err_count),  m_cnt);
        chk({tag, ".wrap_pulse"}, int'(wrap_pulse), int'(m_wr));
        chk({tag, ".exp_count"},  int'(exp_count),  m_exp);
    endtask

    typedef struct {
        bit         rst;
        bit         v;
        logic [7:0] c;
        bit         clr;
        bit         lk;
        bit         ep;
        bit         par;
        bit         stp;
        logic [7:0] cnt;
        bit         wr;
        logic [7:0] expc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit rst, input bit v, input logic [7:0] c, input bit clr,
                                input bit lk, input bit ep, input bit par, input bit stp,
                                input logic [7:0] cnt, input bit wr, input logic [7:0] expc);
        vec_t r;
        r.rst = rst; r.v = v; r.c = c; r.clr = clr;
        r.lk = lk; r.ep = ep; r.par = par; r.stp = stp; r.cnt = cnt; r.wr = wr; r.expc = expc;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: run still active at t=%0t, expected to end earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] src;
        logic [7:0] c;
        bit         rst_r, v_r, clr_r;

        reset = 1'b0; in_valid = 1'b0; in_count = '0; clear = 1'b0;

        //            rst v  c      clr  lk ep par stp cnt    wr exp
        tbl.push_back(mk(H, L, 8'h00, L,  L, L, L,  L,  8'h00, L, 8'h00));
        tbl.push_back(mk(L, H, 8'h01, L,  L, L, L,  L,  8'h00, L, 8'h03));
        tbl.push_back(mk(L, H, 8'h03, L,  L, L, L,  L,  8'h00, L, 8'h05));
        tbl.push_back(mk(L, H, 8'h05, L,  L, L, L,  L,  8'h00, L, 8'h07));
        tbl.push_back(mk(L, H, 8'h07, L,  H, L, L,  L,  8'h00, L, 8'h09));
        tbl.push_back(mk(L, H, 8'h09, L,  H, L, L,  L,  8'h00, L, 8'h0B));
        tbl.push_back(mk(L, L, 8'h44, L,  H, L, L,  L,  8'h00, L, 8'h0B));
        tbl.push_back(mk(H, L, 8'h00, L,  L, L, L,  L,  8'h00, L, 8'h00));
        tbl.push_back(mk(L, H, 8'hF3, L,  L, L, L,  L,  8'h00, L, 8'hF5));
        tbl.push_back(mk(L, H, 8'hF5, L,  L, L, L,  L,  8'h00, L, 8'hF7));
        tbl.push_back(mk(L, H, 8'hF7, L,  L, L, L,  L,  8'h00, L, 8'hF9));
        tbl.push_back(mk(L, H, 8'hF9, L,  H, L, L,  L,  8'h00, L, 8'hFB));
        tbl.push_back(mk(L, H, 8'hFB, L,  H, L, L,  L,  8'h00, L, 8'hFD));
        tbl.push_back(mk(L, H, 8'hFD, L,  H, L, L,  L,  8'h00, L, 8'hFF));
        tbl.push_back(mk(L, H, 8'hFF, L,  H, L, L,  L,  8'h00, L, 8'h01));
        tbl.push_back(mk(L, H, 8'h01, L,  H, L, L,  L,  8'h00, H, 8'h03));
        tbl.push_back(mk(L, H, 8'h03, L,  H, L, L,  L,  8'h00, L, 8'h05));
        tbl.push_back(mk(H, H, 8'h02, H,  L, L, L,  L,  8'h00, L, 8'h00));
        tbl.push_back(mk(L, H, 8'h09, L,  L, L, L,  L,  8'h00, L, 8'h0B));
        tbl.push_back(mk(L, H, 8'h0B, L,  L, L, L,  L,  8'h00, L, 8'h0D));
        tbl.push_back(mk(L, H, 8'h0D, L,  L, L, L,  L,  8'h00, L, 8'h0F));
        tbl.push_back(mk(L, H, 8'h0F, L,  H, L, L,  L,  8'h00, L, 8'h11));
        tbl.push_back(mk(L, H, 8'h15, L,  L, H, L,  H,  8'h01, L, 8'h11));
        tbl.push_back(mk(L, L, 8'h00, L,  L, L, L,  H,  8'h01, L, 8'h11));
        tbl.push_back(mk(L, L, 8'h00, H,  L, L, L,  L,  8'h00, L, 8'h11));
        tbl.push_back(mk(L, H, 8'h11, L,  L, L, L,  L,  8'h00, L, 8'h13));
        tbl.push_back(mk(L, H, 8'h13, L,  L, L, L,  L,  8'h00, L, 8'h15));
        tbl.push_back(mk(L, H, 8'h15, L,  L, L, L,  L,  8'h00, L, 8'h17));
        tbl.push_back(mk(L, H, 8'h17, L,  H, L, L,  L,  8'h00, L, 8'h19));
        tbl.push_back(mk(L, H, 8'h12, H,  L, L, L,  L,  8'h00, L, 8'h19));
        tbl.push_back(mk(L, H, 8'h14, L,  L, H, H,  L,  8'h01, L, 8'h19));
        tbl.push_back(mk(L, L, 8'h00, L,  L, L, H,  L,  8'h01, L, 8'h19));
        tbl.push_back(mk(L, H, 8'h19, L,  L, L, H,  L,  8'h01, L, 8'h1B));
        tbl.push_back(mk(L, H, 8'h1B, H,  L, L, L,  L,  8'h00, L, 8'h1D));
        tbl.push_back(mk(L, H, 8'h1D, L,  L, L, L,  L,  8'h00, L, 8'h1F));
        tbl.push_back(mk(L, H, 8'h1F, L,  H, L, L,  L,  8'h00, L, 8'h21));
        tbl.push_back(mk(L, H, 8'h40, L,  L, H, H,  H,  8'h01, L, 8'h21));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].c, tbl[i].clr);
            chk($sformatf("vec%0d.locked", i),     int'(locked),     int'(tbl[i].lk));
            chk($sformatf("vec%0d.err_pulse", i),  int'(err_pulse),  int'(tbl[i].ep));
            chk($sformatf("vec%0d.err_parity", i), int'(err_parity), int'(tbl[i].par));
            chk($sformatf("vec%0d.err_step", i),   int'(err_step),   int'(tbl[i].stp));
            chk($sformatf("vec%0d.err_count", i),  int'(err_count),  int'(tbl[i].cnt));
            chk($sformatf("vec%0d.wrap_pulse", i), int'(wrap_pulse), int'(tbl[i].wr));
            chk($sformatf("vec%0d.exp_count", i),  int'(exp_count),  int'(tbl[i].expc));
        end

        // Saturation: 300 parity errors while unlocked
        drive(H, L, 8'h00, L);
        for (int k = 0; k < 300; k++) begin
            drive(L, H, 8'($urandom_range(0, 127) * 2), L);
            if (k == 253) chk("sat.cnt_254", int'(err_count), 8'hFE);
            if (k == 254) chk("sat.cnt_255", int'(err_count), 8'hFF);
        end
        chk("sat.err_count",  int'(err_count),  8'hFF);
        chk("sat.err_parity", int'(err_parity), 1);
        chk("sat.err_pulse",  int'(err_pulse),  1);
        chk("sat.locked",     int'(locked),     0);

        // FAULT behaviour: ignored samples, or automatic resync
        drive(H, L, 8'h00, L);
        for (int k = 0; k < 4; k++) drive(L, H, 8'(1 + 2 * k), L);
        chk("flt.locked_before", int'(locked), 1);
        drive(L, H, 8'h0B, L);
        chk("flt.err_pulse", int'(err_pulse), 1);
        chk("flt.err_count", int'(err_count), 1);
        chk("flt.locked",    int'(locked),    0);
        drive(L, H, 8'h21, L);
        chk("flt.no_repulse", int'(err_pulse), 0);
        drive(L, H, 8'h23, L);
        drive(L, H, 8'h25, L);
        drive(L, H, 8'h27, L);
`ifdef ODD_CHK_AUTO_RESYNC_EN
        chk("rsy.locked",    int'(locked),    1);
        chk("rsy.err_count", int'(err_count), 1);
        chk("rsy.err_step",  int'(err_step),  1);
        chk("rsy.exp_count", int'(exp_count), 8'h29);
`else
        chk("ign.locked",    int'(locked),    0);
        chk("ign.exp_count", int'(exp_count), 8'h09);
        drive(L, H, 8'h22, L);
        chk("ign.err_count", int'(err_count), 1);
        chk("ign.err_pulse", int'(err_pulse), 0);
        drive(L, L, 8'h00, H);
        chk("clr.err_count", int'(err_count), 0);
        chk("clr.err_step",  int'(err_step),  0);
        for (int k = 0; k < 4; k++) drive(L, H, 8'(8'h21 + 2 * k), L);
        chk("clr.relocked",  int'(locked),    1);
        chk("clr.exp_count", int'(exp_count), 8'h29);
`endif

        // Random stimulus against the reference model
        drive(H, L, 8'h00, L);
        check_model("rnd_reset");
        src = 8'h01;
        for (int n = 0; n < 2000; n++) begin
            rst_r = ($urandom_range(0, 199) == 0);
            clr_r = ($urandom_range(0, 99) < 4);
            v_r   = ($urandom_range(0, 99) < 85);
            c     = src;
            if ($urandom_range(0, 99) < 8) c = 8'($urandom);
            drive(rst_r, v_r, c, clr_r);
            check_model($sformatf("rnd%0d", n));
            if (v_r) src = src + 8'd2;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
